// File: rtl/bfm_apbslv_pkg.sv
// Shared types and constants for the APB3 completer BFM with internal word memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bfm_apbslv_pkg;

    // Two-phase completer FSM; the encoding is fixed so waveforms read the same across builds.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Completed-transfer counter width; the counter wraps silently.
    localparam int XFER_CNT_W = 16;

    // Value driven on PRDATA whenever there is no valid read response.
    localparam logic [31:0] ZERO_DATA = 32'h0000_0000;

    // True when any byte-address bit above the word index is set (address outside the memory).
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 2)) != 32'h0000_0000;
    endfunction

endpackage

// File: rtl/bfm_apbslv_ram.sv
// Word memory for the APB completer BFM: 2**AW x 32, synchronous write, combinational read.
// Latency: write lands on the clock edge with wr_vld=1; read data follows rd_idx combinationally.
// Backpressure: none; always accepts a write. Whole array cleared asynchronously on reset.
module bfm_apbslv_ram #(
    parameter int AW = 6
) (
    input  logic          PCLK,
    input  logic          PRESETN,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_dat,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_dat
);

    localparam int DEPTH = 2 ** AW;

    logic [31:0] mem [DEPTH];

    // Storage: cleared on reset so every test starts from all-zero contents, else write port.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0000_0000;
            end
        end else if (wr_vld) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/bfm_apb_slave_mem.sv
// APB3 completer BFM with word memory, programmable wait states, PSLVERR decode, transfer count, protocol checker.
// Latency: setup cycle + WAIT_CFG wait cycles + 1 ready cycle (2+WAIT_CFG edges from setup to completion).
// Backpressure: PREADY held low for WAIT_CFG access cycles; optional BFM_APBSLV_ERRINJ_EN adds error at ERR_ADR.
module bfm_apb_slave_mem
    import bfm_apbslv_pkg::*;
#(
    parameter int AW      = 6,
    parameter int WW      = 4,
    parameter int ERR_ADR = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic [31:0]           PADDR,
    input  logic                  PWRITE,
    input  logic                  PENABLE,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    input  logic [WW-1:0]         WAIT_CFG,
    output logic [XFER_CNT_W-1:0] XFER_CNT,
    output logic                  PROT_ERR
);

    localparam logic [AW-1:0] ERR_IDX = AW'(ERR_ADR);

    // FSM state
    apb_state_e state_q;
    apb_state_e state_d;

    // Request captured in the setup phase; the access phase is checked against it
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic                  write_q;
    logic [WW-1:0]         cnt_q;
    logic [AW-1:0]         idx_q;

    // Status
    logic [XFER_CNT_W-1:0] xfer_cnt_q;
    logic                  prot_err_q;

    // Decode
    logic                  ready_int;
    logic                  range_err;
    logic                  inj_err;
    logic                  xfer_err;
    logic                  setup_vld;
    logic                  idle_viol;
    logic                  acc_viol;
    logic                  done_vld;
    logic                  ram_wr_vld;
    logic [31:0]           ram_rd_dat;

    assign idx_q     = addr_q[AW+1:2];
    assign range_err = addr_out_of_range(addr_q, AW);

`ifdef BFM_APBSLV_ERRINJ_EN
    // An in-range access to the chosen word also reports an error.
    assign inj_err = (idx_q == ERR_IDX);
`else
    // ERR_ADR deliberately has no effect in this build; only out-of-range accesses error.
    assign inj_err = (idx_q == ERR_IDX) & 1'b0;
`endif

    assign xfer_err = range_err | inj_err;

    // Ready comes purely from flops so the PADDR path never reaches PREADY.
    assign ready_int = (state_q == ACCESS) && (cnt_q == '0);

    // Next state and per-cycle strobes: setup capture, protocol violations, completion.
    always_comb begin
        state_d   = state_q;
        setup_vld = 1'b0;
        idle_viol = 1'b0;
        acc_viol  = 1'b0;
        done_vld  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup_vld = 1'b1;
                    state_d   = ACCESS;
                end else if (PSEL && PENABLE) begin
                    // Access phase without a preceding setup: flag it and ignore the transfer.
                    idle_viol = 1'b1;
                end
            end
            ACCESS: begin
                // The requester must hold select, enable and the whole request stable until ready.
                if (!PSEL || !PENABLE || (PADDR != addr_q) || (PWRITE != write_q) ||
                    (PWDATA != wdata_q)) begin
                    acc_viol = 1'b1;
                    state_d  = IDLE;
                end else if (ready_int) begin
                    done_vld = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture in setup; wait counter runs down only while the access phase stays legal.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            write_q <= 1'b0;
            cnt_q   <= '0;
        end else if (setup_vld) begin
            addr_q  <= PADDR;
            wdata_q <= PWDATA;
            write_q <= PWRITE;
            cnt_q   <= WAIT_CFG;
        end else if ((state_q == ACCESS) && !acc_viol && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WW'(1);
        end
    end

    // Completed transfers, including error-terminated ones; aborted ones are not counted.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            xfer_cnt_q <= '0;
        end else if (done_vld) begin
            xfer_cnt_q <= xfer_cnt_q + XFER_CNT_W'(1);
        end
    end

    // Sticky protocol-violation flag; only reset clears it.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            prot_err_q <= 1'b0;
        end else if (idle_viol || acc_viol) begin
            prot_err_q <= 1'b1;
        end
    end

    // Errored writes never reach the memory.
    assign ram_wr_vld = done_vld && write_q && !xfer_err;

    bfm_apbslv_ram #(
        .AW (AW)
    ) u_ram (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .wr_vld  (ram_wr_vld),
        .wr_idx  (idx_q),
        .wr_dat  (wdata_q),
        .rd_idx  (idx_q),
        .rd_dat  (ram_rd_dat)
    );

    // Read data and error are only meaningful in the ready cycle and are forced to zero otherwise.
    assign PREADY   = ready_int;
    assign PSLVERR  = ready_int && xfer_err;
    assign PRDATA   = (ready_int && !write_q && !xfer_err) ? ram_rd_dat : ZERO_DATA;
    assign XFER_CNT = xfer_cnt_q;
    assign PROT_ERR = prot_err_q;

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// Bench for the APB3 completer BFM: driver queues expected responses, a monitor checks each completion.
// Latency: expected wait-state count travels with each queued response and is compared at PREADY.
// Backpressure: driver holds the access phase until PREADY, bounded by a cycle budget.
module tb_bfm_apb_slave_mem;

    localparam int AW      = 6;
    localparam int WW      = 4;
    localparam int ERR_ADR = 5;

    logic          PCLK     = 1'b0;
    logic          PRESETN  = 1'b1;
    logic          PSEL     = 1'b0;
    logic [31:0]   PADDR    = 32'h0;
    logic          PWRITE   = 1'b0;
    logic          PENABLE  = 1'b0;
    logic [31:0]   PWDATA   = 32'h0;
    logic [WW-1:0] WAIT_CFG = '0;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [15:0]   XFER_CNT;
    logic          PROT_ERR;

    bfm_apb_slave_mem #(
        .AW      (AW),
        .WW      (WW),
        .ERR_ADR (ERR_ADR)
    ) dut (
        .PCLK     (PCLK),
        .PRESETN  (PRESETN),
        .PSEL     (PSEL),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .WAIT_CFG (WAIT_CFG),
        .XFER_CNT (XFER_CNT),
        .PROT_ERR (PROT_ERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
        int          waits;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   mon_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts wait cycles in each access phase and checks every completion against the queue.
    always @(negedge PCLK) begin
        if (PRESETN && PSEL && PENABLE) begin
            if (!PREADY) begin
                mon_wait++;
                check("wait_prdata_zero", PRDATA, 32'h0);
                check("wait_pslverr_zero", {31'h0, PSLVERR}, 32'h0);
            end else if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_ready: got PREADY=1, expected no pending transfer");
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_prdata"}, PRDATA, mon_e.rdata);
                check({mon_e.name, "_pslverr"}, {31'h0, PSLVERR}, {31'h0, mon_e.slverr});
                check({mon_e.name, "_waits"}, mon_wait, mon_e.waits);
                mon_wait = 0;
            end
        end else begin
            mon_wait = 0;
        end
    end

    // One complete transfer; called just after a rising edge, returns just after the completion edge.
    task automatic apb_xfer(input string name, input logic [31:0] addr, input logic wr,
                            input logic [31:0] wdat, input logic [WW-1:0] wcfg,
                            input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.rdata  = exp_rd;
        e.slverr = exp_err;
        e.waits  = int'(wcfg);
        e.name   = name;
        sb_q.push_back(e);
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PADDR    = addr;
        PWRITE   = wr;
        PWDATA   = wdat;
        WAIT_CFG = wcfg;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        // A mid-transfer WAIT_CFG change must not affect the transfer in flight.
        WAIT_CFG = ~wcfg;
        n = 0;
        @(negedge PCLK);
        while (!PREADY && n < 64) begin
            @(negedge PCLK);
            n++;
        end
        if (!PREADY) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_timeout: got no PREADY in 64 cycles, expected PREADY after %0d waits",
                     name, wcfg);
        end
        @(posedge PCLK);
        #1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a real falling edge so the async clear fires.
        #2 PRESETN = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        check("rst_prdata",   PRDATA, 32'h0);
        check("rst_pready",   {31'h0, PREADY}, 32'h0);
        check("rst_pslverr",  {31'h0, PSLVERR}, 32'h0);
        check("rst_xfer_cnt", {16'h0, XFER_CNT}, 32'h0);
        check("rst_prot_err", {31'h0, PROT_ERR}, 32'h0);
        PRESETN = 1'b1;
        @(posedge PCLK);
        #1;

        // Wait states, and memory is zero after reset.
        apb_xfer("w3_rd04", 32'h0000_0004, 1'b0, 32'h0, 4'd3, 32'h0, 1'b0);

        // Zero-wait write then read, back to back.
        apb_xfer("w0_wr10", 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'd0, 32'h0, 1'b0);
        apb_xfer("w0_rd10", 32'h0000_0010, 1'b0, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
        check("cnt_after_3", {16'h0, XFER_CNT}, 32'd3);

        // Out-of-range write errors and does not alias onto word 0.
        apb_xfer("oor_wr",   32'h0000_1000, 1'b1, 32'h1234_5678, 4'd1, 32'h0, 1'b1);
        apb_xfer("alias_rd", 32'h0000_0000, 1'b0, 32'h0, 4'd1, 32'h0, 1'b0);
        apb_xfer("oor_rd",   32'h0000_1000, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1);
        check("cnt_after_6", {16'h0, XFER_CNT}, 32'd6);
        check("prot_clean",  {31'h0, PROT_ERR}, 32'h0);

        // PSEL dropped during wait states: abort, sticky flag, no write, no count.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0020; PWRITE = 1'b1;
        PWDATA = 32'hCAFE_F00D; WAIT_CFG = 4'd2;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("abort_prot_err", {31'h0, PROT_ERR}, 32'h1);
        check("abort_cnt",      {16'h0, XFER_CNT}, 32'd6);
        check("abort_pready",   {31'h0, PREADY}, 32'h0);
        apb_xfer("abort_rd20", 32'h0000_0020, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);
        check("prot_sticky", {31'h0, PROT_ERR}, 32'h1);
        check("cnt_after_7", {16'h0, XFER_CNT}, 32'd7);

        // Error-injection word.
`ifdef BFM_APBSLV_ERRINJ_EN
        apb_xfer("inj_wr14", 32'h0000_0014, 1'b1, 32'hA5A5_A5A5, 4'd0, 32'h0, 1'b1);
        apb_xfer("inj_rd14", 32'h0000_0014, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1);
`else
        apb_xfer("inj_wr14", 32'h0000_0014, 1'b1, 32'hA5A5_A5A5, 4'd0, 32'h0, 1'b0);
        apb_xfer("inj_rd14", 32'h0000_0014, 1'b0, 32'h0, 4'd0, 32'hA5A5_A5A5, 1'b0);
`endif

        // Last word of the memory, with PADDR[1:0] set to show they are ignored.
        apb_xfer("top_wrfc", 32'h0000_00FF, 1'b1, 32'h0BAD_F00D, 4'd2, 32'h0, 1'b0);
        apb_xfer("top_rdfc", 32'h0000_00FC, 1'b0, 32'h0, 4'd15, 32'h0BAD_F00D, 1'b0);
        check("cnt_after_11", {16'h0, XFER_CNT}, 32'd11);

        // Counter wrap: preload 0xFFFF, one more transfer wraps to 0.
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        check("cnt_preload", {16'h0, XFER_CNT}, 32'h0000_FFFF);
        release dut.xfer_cnt_q;
        apb_xfer("wrap_rd10", 32'h0000_0010, 1'b0, 32'h0, 4'd0, 32'hDEAD_BEEF, 1'b0);
        check("cnt_wrap", {16'h0, XFER_CNT}, 32'h0);
        apb_xfer("post_wrap", 32'h0000_00FC, 1'b0, 32'h0, 4'd1, 32'h0BAD_F00D, 1'b0);
        check("cnt_after_wrap", {16'h0, XFER_CNT}, 32'd1);

        // Reset mid-wait: outputs drop immediately and the pending write is discarded.
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0000_0010; PWRITE = 1'b1;
        PWDATA = 32'h1111_1111; WAIT_CFG = 4'd3;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETN = 1'b0;
        #1;
        check("midrst_prdata",   PRDATA, 32'h0);
        check("midrst_pready",   {31'h0, PREADY}, 32'h0);
        check("midrst_pslverr",  {31'h0, PSLVERR}, 32'h0);
        check("midrst_xfer_cnt", {16'h0, XFER_CNT}, 32'h0);
        check("midrst_prot_err", {31'h0, PROT_ERR}, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETN = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer("cleared_rd10", 32'h0000_0010, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);
        check("cnt_after_rst", {16'h0, XFER_CNT}, 32'd1);

        // Access phase with no setup: flagged, no response, no count.
        PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h0000_0008; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        check("nosetup_pready", {31'h0, PREADY}, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        check("nosetup_prot_err", {31'h0, PROT_ERR}, 32'h1);
        check("nosetup_cnt",      {16'h0, XFER_CNT}, 32'd1);

        repeat (2) @(posedge PCLK);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
